// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write->read bypass, busy scoreboard and a valid/ready state-dump stream
module regfile_mp #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                busy_set_en_i,
    input  logic [AW-1:0]       busy_set_addr_i,
    output logic [NREGS-1:0]    busy_o,
    input  logic                dump_req_i,
    output logic                dump_valid_o,
    input  logic                dump_ready_i,
    output logic [AW-1:0]       dump_idx_o,
    output logic [XLEN-1:0]     dump_data_o,
    output logic                dump_done_o
);
    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;
    state_t          state_q, state_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW-1:0]   idx_q, idx_d;
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NREGS;
    endfunction
    // Ascending port order makes the highest-index port win on address collisions.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_i[w] && in_range(wr_addr_i[w*AW +: AW])) begin
                if (wr_addr_i[w*AW +: AW] != '0) regs_d[wr_addr_i[w*AW +: AW]] = wr_data_i[w*XLEN +: XLEN];
                busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (busy_set_en_i && busy_set_addr_i != '0 && in_range(busy_set_addr_i)) busy_d[busy_set_addr_i] = 1'b1;
    end
    always_comb begin
        rd_data_o = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_addr_i[p*AW +: AW] != '0 && in_range(rd_addr_i[p*AW +: AW])) begin
                rd_data_o[p*XLEN +: XLEN] = regs_q[rd_addr_i[p*AW +: AW]];
                for (int w = 0; w < NWR; w++) begin
                    if (BYPASS != 0 && wr_en_i[w] && wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])
                        rd_data_o[p*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
                end
            end
        end
    end
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dump_valid_o = state_q == DUMP;
        dump_done_o  = state_q == DONE;
        dump_data_o  = dump_valid_o ? regs_q[idx_q] : '0;
        if (state_q == IDLE && dump_req_i) state_d = DUMP;
        if (state_q == DUMP && dump_ready_i) begin
            idx_d   = idx_q == AW'(NREGS - 1) ? '0 : idx_q + 1'b1;
            state_d = idx_q == AW'(NREGS - 1) ? DONE : DUMP;
        end
        if (state_q == DONE) state_d = IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regs_q  <= '{default: '0};
            busy_q  <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end
    assign busy_o     = busy_q;
    assign dump_idx_o = idx_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench for regfile_mp against an array-based reference model
module tb_regfile_mp;
    localparam int XLEN = 64, NREGS = 32, NRD = 2, NWR = 2, BYPASS = 1, AW = 5;
    typedef struct packed {
        logic [NRD-1:0][XLEN-1:0] rd;
        logic [NREGS-1:0]         busy;
        logic                     idle;
    } exp_t;
    typedef struct packed {
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
    } beat_t;
    logic clk = 1'b0;
    logic reset;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic bs_en;
    logic [AW-1:0] bs_addr;
    logic [NREGS-1:0] busy;
    logic dreq, dvalid, dready, ddone;
    logic [AW-1:0] didx;
    logic [XLEN-1:0] ddata;
    int checks = 0, failures = 0, done_cnt = 0, beats_seen = 0;
    logic [XLEN-1:0] m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    exp_t exp_q[$];
    beat_t beat_q[$];

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS)) dut (
        .clk_i(clk), .reset_i(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .busy_set_en_i(bs_en), .busy_set_addr_i(bs_addr), .busy_o(busy),
        .dump_req_i(dreq), .dump_valid_o(dvalid), .dump_ready_i(dready),
        .dump_idx_o(didx), .dump_data_o(ddata), .dump_done_o(ddone)
    );

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_read(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = m_regs[a];
        if (BYPASS != 0)
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && wr_addr[w] == a) v = wr_data[w];
        return v;
    endfunction

    task automatic push_exp(input bit idle);
        exp_t e;
        for (int p = 0; p < NRD; p++) e.rd[p] = ref_read(rd_addr[p]);
        e.busy = m_busy;
        e.idle = idle;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        logic [NREGS-1:0] clr;
        @(posedge clk);
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            clr = '0;
            for (int w = 0; w < NWR; w++)
                if (wr_en[w]) begin
                    if (wr_addr[w] != 0) m_regs[wr_addr[w]] = wr_data[w];
                    clr[wr_addr[w]] = 1'b1;
                end
            m_busy = m_busy & ~clr;
            if (bs_en && bs_addr != 0) m_busy[bs_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic step(input bit idle);
        push_exp(idle);
        tick();
    endtask

    task automatic quiet();
        wr_en = '0;
        bs_en = 1'b0;
        dreq  = 1'b0;
    endtask

    task automatic queue_dump();
        for (int i = 0; i < NREGS; i++) beat_q.push_back('{idx: AW'(i), data: m_regs[i]});
    endtask

    always @(negedge clk) begin
        exp_t e;
        beat_t b;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int p = 0; p < NRD; p++) check($sformatf("rd_data[%0d] addr=%0d", p, rd_addr[p]), rd_data[p], e.rd[p]);
            check("busy", XLEN'(busy), XLEN'(e.busy));
            if (e.idle) begin
                check("idle dump_valid", XLEN'(dvalid), '0);
                check("idle dump_done", XLEN'(ddone), '0);
                check("idle dump_idx", XLEN'(didx), '0);
            end
        end
        if (!dvalid) check("dump_data when not valid", ddata, '0);
        if (dvalid && dready) begin
            beats_seen++;
            if (beat_q.size() == 0) check("unexpected beat idx", XLEN'(didx), XLEN'({XLEN{1'b1}}));
            else begin
                b = beat_q.pop_front();
                check("beat idx", XLEN'(didx), XLEN'(b.idx));
                check($sformatf("beat data idx=%0d", b.idx), ddata, b.data);
            end
        end
        if (ddone) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, b0, k;
        foreach (m_regs[i]) m_regs[i] = '0;
        m_busy = '0;
        reset = 1'b1; dready = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; bs_addr = '0;
        quiet();
        tick();
        reset = 1'b0;
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = {AW'(a), AW'(a)};
            step(1);
        end
        for (int i = 0; i < 40; i++) begin
            wr_en = NWR'($urandom);
            for (int w = 0; w < NWR; w++) begin
                wr_addr[w] = AW'($urandom);
                wr_data[w] = {$urandom, $urandom};
            end
            rd_addr = {AW'($urandom), AW'($urandom)};
            step(1);
        end
        quiet();
        wr_en = 2'b01; wr_addr[0] = 5; wr_data[0] = 64'h1234; rd_addr = {AW'(5), AW'(5)};
        step(1);
        quiet();
        step(1);
        wr_en = 2'b11; wr_addr = {AW'(7), AW'(7)}; wr_data = {64'hB, 64'hA}; rd_addr = {AW'(7), AW'(7)};
        step(1);
        quiet();
        step(1);
        wr_en = 2'b01; wr_addr[0] = 0; wr_data[0] = 64'hFF; rd_addr = '0;
        step(1);
        quiet();
        step(1);
        bs_en = 1'b1; bs_addr = 3;
        step(1);
        quiet(); wr_en = 2'b10; wr_addr[1] = 3; wr_data[1] = 64'h33;
        step(1);
        quiet(); bs_en = 1'b1; bs_addr = 3; wr_en = 2'b01; wr_addr[0] = 3;
        step(1);
        quiet(); bs_en = 1'b1; bs_addr = 0;
        step(1);
        quiet();
        step(1);
        for (int i = 0; i < 300; i++) begin
            wr_en = NWR'($urandom);
            for (int w = 0; w < NWR; w++) begin
                wr_addr[w] = AW'($urandom);
                wr_data[w] = {$urandom, $urandom};
            end
            for (int p = 0; p < NRD; p++)
                rd_addr[p] = ($urandom_range(3) == 0) ? wr_addr[$urandom_range(NWR-1)] : AW'($urandom);
            bs_en = 1'($urandom);
            bs_addr = AW'($urandom);
            step(1);
        end
        quiet();
        for (int i = 1; i < NREGS; i++) begin
            wr_en = 2'b01; wr_addr[0] = AW'(i); wr_data[0] = 64'h100 + 64'(i); rd_addr = {AW'(i), AW'(i - 1)};
            step(1);
        end
        quiet();
        step(1);
        d0 = done_cnt; b0 = beats_seen;
        dreq = 1'b1;
        queue_dump();
        step(1);
        dreq = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 300) begin
            dready = k[0];
            dreq = dvalid & 1'($urandom);
            rd_addr = {AW'($urandom), AW'($urandom)};
            step(0);
            k++;
        end
        quiet(); dready = 1'b0;
        check("dump finished in budget", XLEN'(k < 300), 64'd1);
        for (int i = 0; i < 3; i++) step(1);
        check("dump_done pulses", XLEN'(done_cnt - d0), 64'd1);
        check("dump beats", XLEN'(beats_seen - b0), XLEN'(NREGS));
        check("beats left over", XLEN'(beat_q.size()), '0);
        dreq = 1'b1;
        queue_dump();
        step(1);
        dreq = 1'b0; dready = 1'b1;
        k = 0;
        while (didx != 10 && k < 100) begin
            step(0);
            k++;
        end
        check("reached dump_idx 10", XLEN'(didx), 64'd10);
        d0 = done_cnt;
        reset = 1'b1;
        step(0);
        reset = 1'b0; dready = 1'b0;
        beat_q.delete();
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = {AW'(a), AW'(NREGS - 1 - a)};
            step(1);
        end
        check("no dump_done after reset", XLEN'(done_cnt - d0), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
